// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM peripheral.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pwm_pkg;

  localparam int PWM_STEPS = 256;
  localparam int DUTY_W    = 8;
  localparam int N_OUT     = 16;

  localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;
  localparam logic [DUTY_W-1:0] STEP_LAST = DUTY_W'(PWM_STEPS - 1);

  typedef logic [DUTY_W-1:0] duty_t;
  typedef logic [N_OUT-1:0]  out_vec_t;

  // Prescaler width: clog2 of the divider, never narrower than one bit.
  function automatic int presc_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: clk prescaler feeding an 8-bit free-running step counter.
// Latency: tick/wrap are combinational from the prescaler/step flops.
// Backpressure: none; free-running.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              tick,
  output logic [DUTY_W-1:0] step,
  output logic              wrap
);

  localparam int            PW        = presc_width(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;

  assign tick = (presc == PRESC_MAX);
  assign wrap = tick && (step == STEP_LAST);

  // Prescaler counts 0..CLK_DIV-1 and wraps; it is the only source of tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Step counter advances once per tick and rolls over 255->0 by modulo arithmetic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= '0;
    end else if (tick) begin
      step <= step + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// PWM output stage: per-pin force-low / static-high / shared-PWM select, registered pads.
// Latency: out and period_start are one clk after the step/enable/duty that causes them.
// Backpressure: none; register inputs are sampled every clk. Option macro: PWM_SHADOW_DUTY_EN.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       en_reg_out_7_0,
  input  logic [7:0]       en_reg_out_15_8,
  input  logic [7:0]       en_reg_pwm_7_0,
  input  logic [7:0]       en_reg_pwm_15_8,
  input  logic [7:0]       pwm_duty_cycle,
  output logic [N_OUT-1:0] out,
  output logic             period_start
);

  logic        tick;
  logic        wrap;
  duty_t       step;
  duty_t       duty_eff;
  logic        pwm_raw;
  logic        first_pend;
  out_vec_t    en_out;
  out_vec_t    en_pwm;
  out_vec_t    out_nxt;

  pwm_timebase #(
    .CLK_DIV (CLK_DIV)
  ) u_timebase (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .step  (step),
    .wrap  (wrap)
  );

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

`ifdef PWM_SHADOW_DUTY_EN
  // Shadow duty only reloads at the period boundary so a running pulse is never cut or stretched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_eff <= 8'h00;
    end else if (wrap) begin
      duty_eff <= pwm_duty_cycle;
    end
  end
`else
  assign duty_eff = pwm_duty_cycle;
`endif

  // Compare: full-scale duty means no low step at all, including across the wrap.
  always_comb begin
    pwm_raw = 1'b0;
    if (duty_eff == DUTY_FULL) begin
      pwm_raw = 1'b1;
    end else begin
      pwm_raw = (step < duty_eff);
    end
  end

  // Per-pin select: disabled pins low, enabled pins static high or the shared waveform.
  always_comb begin
    out_nxt = '0;
    for (int i = 0; i < N_OUT; i++) begin
      out_nxt[i] = en_out[i] ? (en_pwm[i] ? pwm_raw : 1'b1) : 1'b0;
    end
  end

  // Only flops drive the pads, so enable changes can never glitch them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= out_nxt;
    end
  end

  // Period marker: pulses after each wrap tick; the step 0 entered from reset is
  // treated as a period too, so the first tick after release also pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_pend   <= 1'b1;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap || (tick && first_pend);
      if (tick) begin
        first_pend <= 1'b0;
      end
    end
  end

endmodule
